// File: rtl/pulse_frame_receiver.sv
// Frame-locking serial-to-parallel receiver: hunts for a programmable frame
// word, then strobes each aligned frame with its popcount and match/error stats.
module pulse_frame_receiver #(
  parameter int WIDTH      = 16,
  parameter int LOSS_LIMIT = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       serial_in,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           pattern,
  output logic                       frame_valid,
  output logic [WIDTH-1:0]           frame_word,
  output logic [$clog2(WIDTH+1)-1:0] ones_count,
  output logic                       locked,
  output logic [7:0]                 match_count,
  output logic [7:0]                 error_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = $clog2(WIDTH);
  localparam int MW = 4;

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
  logic             frame_valid_q, frame_valid_d;
  logic [WIDTH-1:0] frame_word_q, frame_word_d;
  logic [CW-1:0]    ones_count_q, ones_count_d;
  logic             locked_q, locked_d;
  logic [7:0]       match_count_q, match_count_d;
  logic [7:0]       error_count_q, error_count_d;

  logic [WIDTH-1:0] nsr;
  logic             fill_full;
  logic [MW-1:0]    miss_inc;

  // Next-state and output computation for the hunt/lock machine.
  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    fill_d        = fill_q;
    bit_cnt_d     = bit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    frame_valid_d = 1'b0;
    frame_word_d  = frame_word_q;
    ones_count_d  = ones_count_q;
    locked_d      = locked_q;
    match_count_d = match_count_q;
    error_count_d = error_count_q;
    nsr           = {sr_q[WIDTH-2:0], serial_in};
    // Full once the current sample is the WIDTH-th since reset.
    fill_full     = (fill_q >= CW'(WIDTH - 1));
    miss_inc      = miss_cnt_q + 4'd1;

    if (enable) begin
      sr_d = nsr;
      if (fill_q != CW'(WIDTH)) begin
        fill_d = fill_q + CW'(1);
      end else begin
        fill_d = fill_q;
      end

      case (state_q)
        ST_HUNT: begin
          if (fill_full && (nsr == pattern)) begin
            state_d       = ST_LOCKED;
            locked_d      = 1'b1;
            bit_cnt_d     = '0;
            miss_cnt_d    = '0;
            frame_valid_d = 1'b1;
            frame_word_d  = nsr;
            ones_count_d  = popcount(nsr);
            match_count_d = sat_inc(match_count_q);
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          if (bit_cnt_q == BW'(WIDTH - 1)) begin
            bit_cnt_d     = '0;
            frame_valid_d = 1'b1;
            frame_word_d  = nsr;
            ones_count_d  = popcount(nsr);
            if (nsr == pattern) begin
              match_count_d = sat_inc(match_count_q);
              miss_cnt_d    = '0;
            end else begin
              error_count_d = sat_inc(error_count_q);
              if (miss_inc == MW'(LOSS_LIMIT)) begin
                // Lock is dropped but sr/fill survive so hunting resumes immediately.
                state_d    = ST_HUNT;
                locked_d   = 1'b0;
                miss_cnt_d = '0;
              end else begin
                miss_cnt_d = miss_inc;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        default: begin
          state_d  = ST_HUNT;
          locked_d = 1'b0;
        end
      endcase
    end else begin
      frame_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      sr_q          <= '0;
      fill_q        <= '0;
      bit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_word_q  <= '0;
      ones_count_q  <= '0;
      locked_q      <= 1'b0;
      match_count_q <= 8'd0;
      error_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      fill_q        <= fill_d;
      bit_cnt_q     <= bit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_word_q  <= frame_word_d;
      ones_count_q  <= ones_count_d;
      locked_q      <= locked_d;
      match_count_q <= match_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_word  = frame_word_q;
  assign ones_count  = ones_count_q;
  assign locked      = locked_q;
  assign match_count = match_count_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_pulse_frame_receiver.sv
// Directed bench for pulse_frame_receiver: lock, errors, loss/relock,
// enable gaps, mid-frame reset, popcount extremes and counter saturation.
module tb_pulse_frame_receiver;

  logic        clock;
  logic        reset;
  logic        serial_in;
  logic        enable;
  logic [15:0] pattern;
  logic        frame_valid;
  logic [15:0] frame_word;
  logic [4:0]  ones_count;
  logic        locked;
  logic [7:0]  match_count;
  logic [7:0]  error_count;

  int n_cmp = 0;
  int n_err = 0;
  int strobes;
  int total;

  pulse_frame_receiver #(.WIDTH(16), .LOSS_LIMIT(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .serial_in   (serial_in),
    .enable      (enable),
    .pattern     (pattern),
    .frame_valid (frame_valid),
    .frame_word  (frame_word),
    .ones_count  (ones_count),
    .locked      (locked),
    .match_count (match_count),
    .error_count (error_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic b);
    serial_in = b;
    @(posedge clock);
    #1;
  endtask

  // Sends the top n bits of w MSB-first; counts strobes seen after each edge.
  task automatic send_bits(input logic [15:0] w, input int n, output int s);
    s = 0;
    for (int i = 15; i > 15 - n; i--) begin
      tick(w[i]);
      if (frame_valid) s++;
    end
  endtask

  task automatic send_word(input logic [15:0] w, output int s);
    send_bits(w, 16, s);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fv"},  32'(frame_valid), 32'd0);
    chk({tag, "_fw"},  32'(frame_word),  32'd0);
    chk({tag, "_oc"},  32'(ones_count),  32'd0);
    chk({tag, "_lk"},  32'(locked),      32'd0);
    chk({tag, "_mc"},  32'(match_count), 32'd0);
    chk({tag, "_ec"},  32'(error_count), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    reset     = 1'b1;
    enable    = 1'b0;
    serial_in = 1'b0;
    pattern   = 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset   = 1'b0;
    pattern = 16'hA5C3;
    enable  = 1'b1;

    // First lock: no strobe through 15 bits, strobe on the 16th.
    send_bits(16'hA5C3, 15, strobes);
    chk("first_no_early", 32'(strobes), 32'd0);
    tick(1'b1);
    chk("first_fv",  32'(frame_valid), 32'd1);
    chk("first_fw",  32'(frame_word),  32'hA5C3);
    chk("first_oc",  32'(ones_count),  32'd8);
    chk("first_lk",  32'(locked),      32'd1);
    chk("first_mc",  32'(match_count), 32'd1);
    tick(1'b1);
    chk("no_double_fv", 32'(frame_valid), 32'd0);
    send_bits(16'h4B86, 15, strobes);
    chk("second_fv", 32'(frame_valid), 32'd1);
    chk("second_strobes", 32'(strobes), 32'd1);
    send_word(16'hA5C3, strobes);
    send_word(16'hA5C3, strobes);
    chk("four_mc", 32'(match_count), 32'd4);

    // Single-bit error frame then recovery.
    send_word(16'hA5C2, strobes);
    chk("err1_fv", 32'(frame_valid), 32'd1);
    chk("err1_fw", 32'(frame_word),  32'hA5C2);
    chk("err1_ec", 32'(error_count), 32'd1);
    chk("err1_lk", 32'(locked),      32'd1);
    send_word(16'hA5C3, strobes);
    chk("rec_mc", 32'(match_count), 32'd5);
    chk("rec_ec", 32'(error_count), 32'd1);

    // Three consecutive bad frames drop lock on the third strobe.
    send_word(16'hA5C2, strobes);
    send_word(16'hA5C2, strobes);
    chk("loss2_lk", 32'(locked), 32'd1);
    send_word(16'hA5C2, strobes);
    chk("loss3_fv", 32'(frame_valid), 32'd1);
    chk("loss3_lk", 32'(locked),      32'd0);
    chk("loss3_ec", 32'(error_count), 32'd4);

    // 5-bit slip, then aligned pattern relocks on its last bit.
    send_bits(16'h0000, 5, strobes);
    chk("slip_none", 32'(strobes), 32'd0);
    send_word(16'hA5C3, strobes);
    chk("relock_strobes", 32'(strobes), 32'd1);
    chk("relock_fv", 32'(frame_valid), 32'd1);
    chk("relock_lk", 32'(locked),      32'd1);
    chk("relock_mc", 32'(match_count), 32'd6);

    // Enable gap of 5 cycles mid-frame.
    w = 16'hA5C3;
    send_bits(w, 8, strobes);
    chk("gap_pre_none", 32'(strobes), 32'd0);
    chk("gap_fw_hold", 32'(frame_word), 32'hA5C3);
    enable = 1'b0;
    total = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      if (frame_valid) total++;
    end
    chk("gap_none", 32'(total), 32'd0);
    enable = 1'b1;
    total = 0;
    for (int i = 7; i >= 0; i--) begin
      tick(w[i]);
      if (frame_valid) total++;
    end
    chk("gap_post_fv", 32'(frame_valid), 32'd1);
    chk("gap_post_cnt", 32'(total), 32'd1);
    chk("gap_fw", 32'(frame_word),  32'hA5C3);
    chk("gap_mc", 32'(match_count), 32'd7);

    // Mid-frame reset clears everything.
    send_bits(16'hA5C3, 7, strobes);
    reset = 1'b1;
    tick(1'b0);
    chk_all_zero("midrst");
    reset   = 1'b0;
    pattern = 16'h0000;

    // All-zeros pattern: lock after exactly 16 edges.
    send_bits(16'h0000, 15, strobes);
    chk("zero_no_early", 32'(strobes), 32'd0);
    tick(1'b0);
    chk("zero_fv", 32'(frame_valid), 32'd1);
    chk("zero_oc", 32'(ones_count),  32'd0);
    chk("zero_mc", 32'(match_count), 32'd1);

    // Pattern change while locked applies at the next boundary.
    pattern = 16'hFFFF;
    send_word(16'hFFFF, strobes);
    chk("ones_fv", 32'(frame_valid), 32'd1);
    chk("ones_oc", 32'(ones_count),  32'd16);
    chk("ones_mc", 32'(match_count), 32'd2);
    chk("ones_ec", 32'(error_count), 32'd0);

    // Saturation over 300 more matching frames.
    total = 0;
    for (int f = 0; f < 300; f++) begin
      send_word(16'hFFFF, strobes);
      total += strobes;
    end
    chk("sat_strobes", 32'(total), 32'd300);
    chk("sat_mc", 32'(match_count), 32'd255);
    chk("sat_ec", 32'(error_count), 32'd0);
    chk("sat_lk", 32'(locked),      32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
